// File: rtl/fir_sample_source.sv
// fir_sample_source: paced STEP/RAMP test-sample generator with debounced mode toggle.
// Ports:
//   CLOCK_50     in   system clock, rising edge
//   reset        in   asynchronous active-high reset
//   toggleBtn    in   raw active-low push button, asynchronous
//   sample_ready in   downstream accepts sample_data when high with sample_valid
//   sample_valid out  sample_data holds a valid sample
//   sample_data  out  current sample (DATA_W bits)
//   mode         out  0 = STEP, 1 = RAMP
//   overrun      out  sticky: a tick arrived while a sample was still pending
module fir_sample_source #(
   parameter int DATA_W       = 8,
   parameter int SAMPLE_DIV   = 10,
   parameter int DEBOUNCE_CYC = 4
) (
   input  logic              CLOCK_50,
   input  logic              reset,
   input  logic              toggleBtn,
   input  logic              sample_ready,
   output logic              sample_valid,
   output logic [DATA_W-1:0] sample_data,
   output logic              mode,
   output logic              overrun
);
   localparam int DIV_W = $clog2(SAMPLE_DIV);
   localparam int DEB_W = $clog2(DEBOUNCE_CYC) + 1;
   localparam logic [0:0] WAIT = 1'b0;
   localparam logic [0:0] HOLD = 1'b1;
   logic              sync1_q, sync2_q, stable_q, stable_d;
   logic [DEB_W-1:0]  deb_cnt_q, deb_cnt_d;
   logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
   logic [3:0]        idx_q, idx_d;
   logic              mode_q, mode_d, overrun_q, overrun_d;
   logic [0:0]        state_q, state_d;
   logic [DATA_W-1:0] data_q, data_d, pattern;
   logic              deb_hit, press, tick, load;
   always_comb begin
      deb_hit   = (sync2_q != stable_q) && (deb_cnt_q == DEB_W'(DEBOUNCE_CYC - 1));
      deb_cnt_d = (sync2_q == stable_q || deb_hit) ? '0 : deb_cnt_q + 1'b1;
      stable_d  = deb_hit ? sync2_q : stable_q;
      // only the accepted high-to-low edge counts as a press; releases are ignored
      press     = deb_hit & ~sync2_q;
      tick      = div_cnt_q == DIV_W'(SAMPLE_DIV - 1);
      div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
      // a tick loads from WAIT, or back-to-back from HOLD when the current sample is taken
      load      = tick && (state_q == WAIT || sample_ready);
      pattern   = mode_q ? DATA_W'(idx_q) << (DATA_W - 4) : {DATA_W{idx_q[3]}};
      data_d    = load ? pattern : data_q;
      state_d   = load ? HOLD : (state_q == HOLD && sample_ready) ? WAIT : state_q;
      // a press restarts the pattern even if a load happens in the same cycle
      idx_d     = press ? '0 : load ? idx_q + 1'b1 : idx_q;
      mode_d    = mode_q ^ press;
      overrun_d = overrun_q | (tick && state_q == HOLD && !sample_ready);
   end
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         sync1_q   <= 1'b1;
         sync2_q   <= 1'b1;
         stable_q  <= 1'b1;
         deb_cnt_q <= '0;
         div_cnt_q <= '0;
         idx_q     <= '0;
         mode_q    <= 1'b0;
         overrun_q <= 1'b0;
         state_q   <= WAIT;
         data_q    <= '0;
      end else begin
         sync1_q   <= toggleBtn;
         sync2_q   <= sync1_q;
         stable_q  <= stable_d;
         deb_cnt_q <= deb_cnt_d;
         div_cnt_q <= div_cnt_d;
         idx_q     <= idx_d;
         mode_q    <= mode_d;
         overrun_q <= overrun_d;
         state_q   <= state_d;
         data_q    <= data_d;
      end
   end
   assign sample_valid = state_q == HOLD;
   assign sample_data  = data_q;
   assign mode         = mode_q;
   assign overrun      = overrun_q;
endmodule

// File: tb/tb_fir_sample_source.sv
// tb_fir_sample_source: directed bench for fir_sample_source (DATA_W=8, SAMPLE_DIV=10, DEBOUNCE_CYC=4).
module tb_fir_sample_source;
   logic       clk = 1'b0, rst = 1'b1, btn = 1'b1, ready = 1'b1;
   logic       valid, mode, ovr;
   logic [7:0] data;
   int         pass_cnt = 0, total = 0, tog = 0, cyc = 0;
   logic       mode_prev = 1'b0;

   fir_sample_source #(.DATA_W(8), .SAMPLE_DIV(10), .DEBOUNCE_CYC(4)) dut (
      .CLOCK_50(clk), .reset(rst), .toggleBtn(btn), .sample_ready(ready),
      .sample_valid(valid), .sample_data(data), .mode(mode), .overrun(ovr));

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;
   always @(negedge clk) begin
      if (mode !== mode_prev) tog++;
      mode_prev = mode;
   end

   initial begin
      #400000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1);
   end

   // waits for the next valid sample; returns at posedge+1 after capture
   task automatic get_sample(output logic [7:0] d, output int t);
      d = 'x;
      t = -1;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (valid === 1'b1) begin
            d = data;
            t = cyc;
            break;
         end
      end
      if (t < 0) begin
         total++;
         $display("FAIL sample_timeout got no valid want valid within 30 cycles");
      end
      @(posedge clk);
      #1;
   endtask

   task automatic press_btn(input int n);
      btn = 1'b0;
      repeat (n) @(posedge clk);
      #1 btn = 1'b1;
   endtask

   task automatic test_reset();
      logic [7:0] d, e;
      int t, t0;
      logic early;
      rst = 1'b1; ready = 1'b1; btn = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      total++;
      if ({valid, data, mode, ovr} !== 11'd0) $display("FAIL reset_outputs got %b want 0", {valid, data, mode, ovr});
      else pass_cnt++;
      rst = 1'b0;
      early = 1'b0;
      for (int i = 1; i <= 9; i++) begin
         @(posedge clk);
         #1 early |= valid;
      end
      total++;
      if (early !== 1'b0) $display("FAIL early_valid got %b want 0", early);
      else pass_cnt++;
      @(posedge clk);
      #1 t0 = cyc;
      total++;
      if (valid !== 1'b1 || data !== 8'h00) $display("FAIL first_sample got v=%b d=%h want v=1 d=00", valid, data);
      else pass_cnt++;
      @(posedge clk);
      #1;
      total++;
      if (valid !== 1'b0) $display("FAIL valid_one_cycle got %b want 0", valid);
      else pass_cnt++;
      for (int k = 1; k <= 16; k++) begin
         get_sample(d, t);
         e = ((k % 16) >= 8) ? 8'hFF : 8'h00;
         total++;
         if (d !== e) $display("FAIL step_seq[%0d] got %h want %h", k, d, e);
         else pass_cnt++;
         if (k == 1) begin
            total++;
            if (t - t0 !== 10) $display("FAIL sample_period got %0d want 10", t - t0);
            else pass_cnt++;
         end
      end
   endtask

   task automatic test_press_toggle();
      logic [7:0] d, e;
      int t;
      tog = 0;
      press_btn(8);
      for (int k = 0; k <= 16; k++) begin
         get_sample(d, t);
         e = 8'((k % 16) * 16);
         total++;
         if (d !== e) $display("FAIL ramp_seq[%0d] got %h want %h", k, d, e);
         else pass_cnt++;
      end
      total++;
      if (mode !== 1'b1) $display("FAIL press_mode got %b want 1", mode);
      else pass_cnt++;
      total++;
      if (tog !== 1) $display("FAIL press_toggles got %0d want 1", tog);
      else pass_cnt++;
   endtask

   task automatic test_glitch();
      logic [7:0] d, e;
      int t;
      tog = 0;
      press_btn(2);
      for (int k = 1; k <= 3; k++) begin
         get_sample(d, t);
         e = 8'(k * 16);
         total++;
         if (d !== e) $display("FAIL glitch_seq[%0d] got %h want %h", k, d, e);
         else pass_cnt++;
      end
      total++;
      if (mode !== 1'b1 || tog !== 0) $display("FAIL glitch_mode got mode=%b toggles=%0d want mode=1 toggles=0", mode, tog);
      else pass_cnt++;
   endtask

   task automatic test_overrun();
      logic [7:0] d;
      int t, bad;
      logic saw;
      ready = 1'b0;
      saw = 1'b0;
      bad = 0;
      repeat (25) begin
         @(negedge clk);
         if (valid === 1'b1) begin
            saw = 1'b1;
            if (data !== 8'h40) bad++;
         end
      end
      total++;
      if (saw !== 1'b1) $display("FAIL hold_valid got %b want 1", saw);
      else pass_cnt++;
      total++;
      if (bad !== 0) $display("FAIL hold_stable got %0d changed cycles want 0", bad);
      else pass_cnt++;
      total++;
      if (ovr !== 1'b1) $display("FAIL overrun_set got %b want 1", ovr);
      else pass_cnt++;
      @(posedge clk);
      #1 ready = 1'b1;
      @(posedge clk);
      #1;
      get_sample(d, t);
      total++;
      if (d !== 8'h50) $display("FAIL after_overrun got %h want 50", d);
      else pass_cnt++;
      get_sample(d, t);
      total++;
      if (d !== 8'h60) $display("FAIL after_overrun2 got %h want 60", d);
      else pass_cnt++;
      total++;
      if (ovr !== 1'b1) $display("FAIL overrun_sticky got %b want 1", ovr);
      else pass_cnt++;
   endtask

   task automatic test_async_reset();
      logic [7:0] d;
      int t;
      ready = 1'b0;
      get_sample(d, t);
      total++;
      if (valid !== 1'b1 || mode !== 1'b1 || d !== 8'h70) $display("FAIL pre_reset got v=%b m=%b d=%h want v=1 m=1 d=70", valid, mode, d);
      else pass_cnt++;
      #2 rst = 1'b1;
      #1;
      total++;
      if ({valid, data, mode, ovr} !== 11'd0) $display("FAIL async_reset got %b want 0", {valid, data, mode, ovr});
      else pass_cnt++;
      test_reset();
   endtask

   task automatic test_two_presses();
      logic [7:0] d, e;
      int t;
      tog = 0;
      press_btn(8);
      for (int k = 0; k < 3; k++) begin
         get_sample(d, t);
         e = 8'(k * 16);
         total++;
         if (d !== e) $display("FAIL press1_seq[%0d] got %h want %h", k, d, e);
         else pass_cnt++;
      end
      total++;
      if (mode !== 1'b1) $display("FAIL press1_mode got %b want 1", mode);
      else pass_cnt++;
      press_btn(8);
      for (int k = 0; k < 9; k++) begin
         get_sample(d, t);
         e = (k >= 8) ? 8'hFF : 8'h00;
         total++;
         if (d !== e) $display("FAIL press2_seq[%0d] got %h want %h", k, d, e);
         else pass_cnt++;
      end
      total++;
      if (mode !== 1'b0 || tog !== 2) $display("FAIL press2_mode got mode=%b toggles=%0d want mode=0 toggles=2", mode, tog);
      else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_press_toggle();
      test_glitch();
      test_overrun();
      test_async_reset();
      test_two_presses();
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end
endmodule
